// File: rtl/arm_pkg.sv
// Shared ARM32 pipeline definitions: ALU command encodings and the ID/EXE
// control bundle, with the all-zero NOP used for bubbles and flushes.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic       WB_EN;
        logic       MEM_R_EN;
        logic       MEM_W_EN;
        logic       B;
        logic       S;
        logic       imm;
        logic [3:0] EXE_CMD;
    } id_exe_ctrl_t;

    // A NOP must keep WB_EN low so the hazard unit never sees a false dependency.
    localparam id_exe_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low clear and a hold input
// that takes precedence over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (!hold && inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: one-cycle capture of decoded operands and control,
// with freeze hold, flush/hazard NOP insertion and saturating debug counters.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic [DATA_W-1:0] PC_ID,
    input  logic              WB_EN_ID,
    input  logic              MEM_R_EN_ID,
    input  logic              MEM_W_EN_ID,
    input  logic              B_ID,
    input  logic              S_ID,
    input  logic              imm_ID,
    input  logic [3:0]        EXE_CMD_ID,
    input  logic [DATA_W-1:0] val_Rn_ID,
    input  logic [DATA_W-1:0] val_Rm_ID,
    input  logic [11:0]       shift_operand_ID,
    input  logic [23:0]       signed_imm_24_ID,
    input  logic [3:0]        dest_ID,
    input  logic [3:0]        src1_ID,
    input  logic [3:0]        src2_ID,
    input  logic [3:0]        SR_ID,
    output logic [DATA_W-1:0] PC_EXE,
    output logic              WB_EN_EXE,
    output logic              MEM_R_EN_EXE,
    output logic              MEM_W_EN_EXE,
    output logic              B_EXE,
    output logic              S_EXE,
    output logic              imm_EXE,
    output logic [3:0]        EXE_CMD_EXE,
    output logic [DATA_W-1:0] val_Rn_EXE,
    output logic [DATA_W-1:0] val_Rm_EXE,
    output logic [11:0]       shift_operand_EXE,
    output logic [23:0]       signed_imm_24_EXE,
    output logic [3:0]        dest_EXE,
    output logic [3:0]        src1_EXE,
    output logic [3:0]        src2_EXE,
    output logic [3:0]        SR_EXE,
    output logic              valid_EXE,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    id_exe_ctrl_t      ctrl_id;
    id_exe_ctrl_t      ctrl_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] val_rn_reg;
    logic [DATA_W-1:0] val_rm_reg;
    logic [11:0]       shift_operand_reg;
    logic [23:0]       signed_imm_24_reg;
    logic [3:0]        dest_reg;
    logic [3:0]        src1_reg;
    logic [3:0]        src2_reg;
    logic [3:0]        sr_reg;
    logic              valid_reg;
    logic              insert_nop;

    assign ctrl_id = '{
        WB_EN:    WB_EN_ID,
        MEM_R_EN: MEM_R_EN_ID,
        MEM_W_EN: MEM_W_EN_ID,
        B:        B_ID,
        S:        S_ID,
        imm:      imm_ID,
        EXE_CMD:  EXE_CMD_ID
    };

    assign insert_nop = flush || hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_reg          <= CTRL_NOP;
            pc_reg            <= '0;
            val_rn_reg        <= '0;
            val_rm_reg        <= '0;
            shift_operand_reg <= '0;
            signed_imm_24_reg <= '0;
            dest_reg          <= '0;
            src1_reg          <= '0;
            src2_reg          <= '0;
            sr_reg            <= '0;
            valid_reg         <= 1'b0;
        end else if (!freeze) begin
            // Bubbles and flushes clear the data fields too, so dest_EXE reads 0.
            if (insert_nop) begin
                ctrl_reg          <= CTRL_NOP;
                pc_reg            <= '0;
                val_rn_reg        <= '0;
                val_rm_reg        <= '0;
                shift_operand_reg <= '0;
                signed_imm_24_reg <= '0;
                dest_reg          <= '0;
                src1_reg          <= '0;
                src2_reg          <= '0;
                sr_reg            <= '0;
                valid_reg         <= 1'b0;
            end else begin
                ctrl_reg          <= ctrl_id;
                pc_reg            <= PC_ID;
                val_rn_reg        <= val_Rn_ID;
                val_rm_reg        <= val_Rm_ID;
                shift_operand_reg <= shift_operand_ID;
                signed_imm_24_reg <= signed_imm_24_ID;
                dest_reg          <= dest_ID;
                src1_reg          <= src1_ID;
                src2_reg          <= src2_ID;
                sr_reg            <= SR_ID;
                valid_reg         <= 1'b1;
            end
        end
    end

    assign PC_EXE            = pc_reg;
    assign WB_EN_EXE         = ctrl_reg.WB_EN;
    assign MEM_R_EN_EXE      = ctrl_reg.MEM_R_EN;
    assign MEM_W_EN_EXE      = ctrl_reg.MEM_W_EN;
    assign B_EXE             = ctrl_reg.B;
    assign S_EXE             = ctrl_reg.S;
    assign imm_EXE           = ctrl_reg.imm;
    assign EXE_CMD_EXE       = ctrl_reg.EXE_CMD;
    assign val_Rn_EXE        = val_rn_reg;
    assign val_Rm_EXE        = val_rm_reg;
    assign shift_operand_EXE = shift_operand_reg;
    assign signed_imm_24_EXE = signed_imm_24_reg;
    assign dest_EXE          = dest_reg;
    assign src1_EXE          = src1_reg;
    assign src2_EXE          = src2_reg;
    assign SR_EXE            = sr_reg;
    assign valid_EXE         = valid_reg;

    // A simultaneous flush and hazard is accounted as a flush only.
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard && !flush),
        .hold  (freeze),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .hold  (freeze),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized self-checking bench for id_exe_reg against an instruction-level
// model; counters run at 2 bits so saturation is reachable.
module tb_id_exe_reg;

    localparam int DW      = 32;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic          wb;
        logic          mr;
        logic          mw;
        logic          b;
        logic          s;
        logic          imm;
        logic [3:0]    cmd;
        logic [DW-1:0] rn;
        logic [DW-1:0] rm;
        logic [11:0]   sh;
        logic [23:0]   simm;
        logic [3:0]    dest;
        logic [3:0]    src1;
        logic [3:0]    src2;
        logic [3:0]    sr;
    } instr_t;

    logic clk = 1'b0;
    logic rst, freeze, flush, hazard;
    instr_t id_in;
    instr_t got;

    logic [DW-1:0] PC_EXE, val_Rn_EXE, val_Rm_EXE;
    logic          WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, B_EXE, S_EXE, imm_EXE, valid_EXE;
    logic [3:0]    EXE_CMD_EXE, dest_EXE, src1_EXE, src2_EXE, SR_EXE;
    logic [11:0]   shift_operand_EXE;
    logic [23:0]   signed_imm_24_EXE;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    instr_t exp_exe;
    logic   exp_valid;
    int     exp_bub, exp_fl;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.CNT_W(CW), .DATA_W(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .hazard            (hazard),
        .PC_ID             (id_in.pc),
        .WB_EN_ID          (id_in.wb),
        .MEM_R_EN_ID       (id_in.mr),
        .MEM_W_EN_ID       (id_in.mw),
        .B_ID              (id_in.b),
        .S_ID              (id_in.s),
        .imm_ID            (id_in.imm),
        .EXE_CMD_ID        (id_in.cmd),
        .val_Rn_ID         (id_in.rn),
        .val_Rm_ID         (id_in.rm),
        .shift_operand_ID  (id_in.sh),
        .signed_imm_24_ID  (id_in.simm),
        .dest_ID           (id_in.dest),
        .src1_ID           (id_in.src1),
        .src2_ID           (id_in.src2),
        .SR_ID             (id_in.sr),
        .PC_EXE            (PC_EXE),
        .WB_EN_EXE         (WB_EN_EXE),
        .MEM_R_EN_EXE      (MEM_R_EN_EXE),
        .MEM_W_EN_EXE      (MEM_W_EN_EXE),
        .B_EXE             (B_EXE),
        .S_EXE             (S_EXE),
        .imm_EXE           (imm_EXE),
        .EXE_CMD_EXE       (EXE_CMD_EXE),
        .val_Rn_EXE        (val_Rn_EXE),
        .val_Rm_EXE        (val_Rm_EXE),
        .shift_operand_EXE (shift_operand_EXE),
        .signed_imm_24_EXE (signed_imm_24_EXE),
        .dest_EXE          (dest_EXE),
        .src1_EXE          (src1_EXE),
        .src2_EXE          (src2_EXE),
        .SR_EXE            (SR_EXE),
        .valid_EXE         (valid_EXE),
        .bubble_cnt        (bubble_cnt),
        .flush_cnt         (flush_cnt)
    );

    assign got = '{pc: PC_EXE, wb: WB_EN_EXE, mr: MEM_R_EN_EXE, mw: MEM_W_EN_EXE,
                   b: B_EXE, s: S_EXE, imm: imm_EXE, cmd: EXE_CMD_EXE,
                   rn: val_Rn_EXE, rm: val_Rm_EXE, sh: shift_operand_EXE,
                   simm: signed_imm_24_EXE, dest: dest_EXE, src1: src1_EXE,
                   src2: src2_EXE, sr: SR_EXE};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic rand_id();
        id_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: apply controls, advance the model, compare every output.
    task automatic step(input logic rs, input logic fr, input logic fl, input logic hz);
        rst = rs; freeze = fr; flush = fl; hazard = hz;
        @(posedge clk);
        if (!rs) begin
            exp_exe = '0; exp_valid = 1'b0; exp_bub = 0; exp_fl = 0;
        end else if (!fr) begin
            if (fl || hz) begin
                exp_exe = '0; exp_valid = 1'b0;
            end else begin
                exp_exe = id_in; exp_valid = 1'b1;
            end
            if (fl) exp_fl = (exp_fl < CNT_MAX) ? exp_fl + 1 : exp_fl;
            else if (hz) exp_bub = (exp_bub < CNT_MAX) ? exp_bub + 1 : exp_bub;
        end
        #1;
        check("ctrl", {got.wb, got.mr, got.mw, got.b, got.s, got.imm, got.cmd},
                      {exp_exe.wb, exp_exe.mr, exp_exe.mw, exp_exe.b, exp_exe.s, exp_exe.imm, exp_exe.cmd});
        check("pc", got.pc, exp_exe.pc);
        check("rn_rm", {got.rn, got.rm}, {exp_exe.rn, exp_exe.rm});
        check("fields", {got.sh, got.simm, got.dest, got.src1, got.src2, got.sr},
                        {exp_exe.sh, exp_exe.simm, exp_exe.dest, exp_exe.src1, exp_exe.src2, exp_exe.sr});
        check("valid", valid_EXE, exp_valid);
        check("bubble_cnt", bubble_cnt, exp_bub);
        check("flush_cnt", flush_cnt, exp_fl);
        $display("cycle t=%0t rst=%0b frz=%0b fl=%0b hz=%0b dest=%0d valid=%0b bub=%0d fl_cnt=%0d",
                 $time, rs, fr, fl, hz, dest_EXE, valid_EXE, bubble_cnt, flush_cnt);
    endtask

    initial begin
        logic [CW-1:0] sat_seq [5];
        int            fl_before, bub_before;
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
        exp_exe = '0; exp_valid = 1'b0; exp_bub = 0; exp_fl = 0;
        id_in = '1;
        @(negedge clk);

        // Reset with every ID input high
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_dest", dest_EXE, 4'd0);
        check("rst_valid", valid_EXE, 1'b0);

        // Normal load
        rand_id();
        id_in.pc = 32'h104; id_in.dest = 4'd3; id_in.wb = 1'b1; id_in.cmd = 4'h2;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("load_pc", PC_EXE, 32'h104);
        check("load_dest", dest_EXE, 4'd3);
        check("load_wb", WB_EN_EXE, 1'b1);
        check("load_valid", valid_EXE, 1'b1);

        // Hazard bubble
        rand_id();
        id_in.wb = 1'b1; id_in.dest = 4'd5;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("bub_wb", WB_EN_EXE, 1'b0);
        check("bub_dest", dest_EXE, 4'd0);
        check("bub_cnt1", bubble_cnt, 2'd1);

        // Freeze holds everything, pending flush applied on release
        rand_id();
        id_in.dest = 4'd7;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_id();
            step(1'b1, 1'b1, 1'b1, $urandom_range(0, 1));
            check("frz_dest", dest_EXE, 4'd7);
            check("frz_flush_cnt", flush_cnt, 2'd0);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("frz_rel_valid", valid_EXE, 1'b0);
        check("frz_rel_flush_cnt", flush_cnt, 2'd1);

        // Simultaneous flush and hazard
        rand_id();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("both_flush_cnt", flush_cnt, 2'd2);
        check("both_bubble_cnt", bubble_cnt, 2'd1);

        // Saturation, then reset during the stall
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            rand_id();
            step(1'b1, 1'b0, 1'b0, 1'b1);
            check("sat_seq", bubble_cnt, sat_seq[i]);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_rst", bubble_cnt, 2'd0);

        // Reset during freeze
        rand_id();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_frz_valid", valid_EXE, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_id();
            fl_before  = exp_fl;
            bub_before = exp_bub;
            step(($urandom_range(0, 99) >= 3),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 25));
            if (flush_cnt != fl_before[CW-1:0] && bubble_cnt != bub_before[CW-1:0] && rst)
                check("one_counter_moves", 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the ARM32 five-stage core.
- Captures decoded ID-stage operands and control every cycle.
- Inserts a bubble when the hazard unit stalls ID, and clears on a taken branch.
- Holds all state while the cache/SRAM freeze is asserted.
- Supplies WB_EN_EXE and dest_EXE to the hazard unit and the forwarding path.
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- CNT_W, 16, width of each performance counter.
- DATA_W, 32, width of PC and register values.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- freeze  in  1  memory/cache not ready; hold every register
- flush  in  1  branch taken in EXE; squash the instruction entering EXE
- hazard  in  1  stall from the hazard unit; insert a bubble
- PC_ID  in  DATA_W  PC+4 of the ID instruction
- WB_EN_ID, MEM_R_EN_ID, MEM_W_EN_ID, B_ID, S_ID, imm_ID  in  1 each  decoded control
- EXE_CMD_ID  in  4  ALU command
- val_Rn_ID, val_Rm_ID  in  DATA_W  register-file read data
- shift_operand_ID  in  12  operand-2 field
- signed_imm_24_ID  in  24  branch offset
- dest_ID, src1_ID, src2_ID  in  4 each  register numbers
- SR_ID  in  4  status flags NZCV
- *_EXE outputs  out  widths as inputs  registered copies of every *_ID input above
- valid_EXE  out  1  EXE holds a real instruction
- bubble_cnt  out  CNT_W  bubbles inserted
- flush_cnt  out  CNT_W  flushes performed

Behaviour:
- All registers update on posedge clk only.
- rst low: all outputs become 0, including valid_EXE and both counters. rst low overrides every other input in that cycle.
- Update priority on each cycle with rst high: freeze > flush > hazard > normal load.
- freeze=1:
  - Every register, including the counters, holds its value.
  - flush and hazard are ignored. Upstream keeps flush asserted until freeze drops, so no flush is lost.
- flush=1, freeze=0:
  - Load a NOP: WB_EN, MEM_R_EN, MEM_W_EN, B, S and valid all 0.
  - Data fields also 0, so dest_EXE=0.
  - flush_cnt increments.
- hazard=1, no freeze, no flush:
  - Load the same NOP.
  - bubble_cnt increments.
  - Stalling the IF/ID register is the upstream block's job.
- Normal load: every *_EXE field takes its *_ID value; valid_EXE=1.
- flush and hazard in the same cycle: counts as a flush only. bubble_cnt is unchanged.
- Latency: exactly one cycle from ID to EXE. There is no combinational path from any input to any output.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The NOP guarantees WB_EN_EXE=0, so the hazard unit never sees a false dependency from a bubble.
- Reset in the middle of a freeze still clears everything on the next edge.

Decomposition:
- Shared package arm_pkg holds:
  - EXE_CMD encodings.
  - A packed struct id_exe_ctrl_t (WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, EXE_CMD).
  - Constant CTRL_NOP, all zeros.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, hold, count), instantiated twice for bubble_cnt and flush_cnt.

Test Plan:
- Reset: drive rst=0 for 2 cycles with all *_ID inputs 1s -> all outputs 0, bubble_cnt=0, flush_cnt=0.
- Normal load: PC_ID=0x104, dest_ID=3, WB_EN_ID=1, EXE_CMD_ID=0x2 -> one cycle later PC_EXE=0x104, dest_EXE=3, WB_EN_EXE=1, valid_EXE=1.
- Hazard bubble: hazard=1 for one cycle while WB_EN_ID=1 and dest_ID=5 -> next cycle WB_EN_EXE=0, dest_EXE=0, valid_EXE=0, bubble_cnt=1.
- Freeze hold: load dest_ID=7, then freeze=1 for 4 cycles with flush=1 and changing inputs -> dest_EXE stays 7, flush_cnt unchanged. Release freeze with flush still 1 -> NOP loaded, flush_cnt=1.
- Simultaneous flush and hazard: flush=1 and hazard=1 together -> NOP loaded, flush_cnt increments by 1, bubble_cnt unchanged.
- Saturation with CNT_W=2: hold hazard=1 for 5 cycles -> bubble_cnt reads 1, 2, 3, 3, 3. Then pull rst low mid-stall -> bubble_cnt=0.
